fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//  Drains a sync_fifo (1-cycle registered read) and presents its words as a valid/ready
//  pixel stream with frame/line markers (out_sof, out_last). Sits directly downstream of
//  the FIFO, feeding the ISP pipeline. Hides FIFO read latency with a 2-entry prefetch
//  buffer so it sustains 1 word/cycle under continuous out_ready.
// PARAMETERS
//  DW        8    data width, must equal FIFO data width
//  LINE_LEN  640  words per line (>=2)
//  LINES     480  lines per frame (>=1)
// PORTS
//  clk          in   1   single clock; FIFO and stream sides both on clk
//  rst          in   1   synchronous, active-high reset
//  fifo_rempty  in   1   FIFO empty flag
//  fifo_ren     out  1   FIFO read enable
//  fifo_rdata   in   DW  FIFO read data, valid the cycle after an accepted fifo_ren
//  out_valid    out  1   stream word valid
//  out_ready    in   1   downstream accepts word
//  out_data     out  DW  stream word
//  out_sof      out  1   qualifies out_data: first word of frame (col 0, row 0)
//  out_last     out  1   qualifies out_data: last word of line (col LINE_LEN-1)
//  frame_done   out  1   1-cycle pulse, cycle after last word of frame is transferred
// BEHAVIOUR
//  - Reset: fifo_ren=0, out_valid=0, out_data=0, out_sof=0, out_last=0, frame_done=0;
//    buffer cleared, in-flight flag cleared, col=row=0. Reset mid-operation discards buffered
//    and in-flight words (they are lost; upstream flushes FIFO alongside). Next word out -> sof.
//  - FIFO read: fifo_ren = !fifo_rempty && (cnt + inflight - pop) < 2, where cnt = buffered
//    words (0..2), inflight = ren issued last cycle, pop = out_valid && out_ready. fifo_ren is
//    never asserted while fifo_rempty=1. inflight <= fifo_ren (registered).
//  - Capture: when inflight=1, fifo_rdata is written to buffer tail that cycle. Buffer never
//    overflows (guaranteed by the ren rule); overflow is an assertion failure in sim.
//  - Latency: ren in cycle n -> word on out_data with out_valid=1 no earlier than cycle n+2;
//    with empty buffer and out_ready=1, exactly n+2. Continuous FIFO data + out_ready=1 ->
//    out_valid high every cycle after the first word.
//  - Handshake: transfer iff out_valid && out_ready. While out_valid && !out_ready, out_data,
//    out_sof, out_last held stable. out_valid never drops without a transfer (except rst).
//  - Buffer order strictly FIFO; simultaneous capture and pop in one cycle is allowed and
//    keeps cnt unchanged. Output registers driven from buffer head.
//  - Counters advance only on transfer: col wraps LINE_LEN-1 -> 0 and increments row; row
//    wraps LINES-1 -> 0. out_sof = (col==0 && row==0); out_last = (col==LINE_LEN-1).
//  - frame_done: registered, high for the single cycle following transfer of the word with
//    col==LINE_LEN-1 && row==LINES-1; next frame may start the same cycle frame_done is high.
//  - Widths: col $clog2(LINE_LEN), row $clog2(LINES); no arithmetic on data path.
// TESTING (LINE_LEN=4, LINES=2, DW=8, sync_fifo #(8,5) model upstream)
//  1 Hold rst=1 3 cycles with FIFO non-empty -> fifo_ren=0, all outputs 0 throughout.
//  2 Preload 0x01..0x08, out_ready=1 -> ren first cycle, out_valid from +2 for 8 consecutive
//    cycles, data 0x01..0x08, sof on 0x01 only, last on 0x04,0x08, frame_done after 0x08.
//  3 Preload 0x10..0x17, out_ready=0 for 5 cycles then 1 -> out_data=0x10 held stable,
//    exactly 2 ren pulses while stalled, then 0x10..0x17 in order, no loss/duplication.
//  4 FIFO empty 10 cycles, then single write 0x55 -> fifo_ren=0 while empty; 0x55 out with
//    sof=1; out_valid drops after transfer.
//  5 Stream 0x20,0x21 then rst 1 cycle, then write 0x30.. -> 0x30 has sof=1, col restarts
//    at 0, last on 4th word after reset.
//  6 1000 random words, random write gaps and random out_ready (50%) -> scoreboard order
//    match, sof/last every 8/4 words, frame_done count = 125, ren never with rempty=1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency sync FIFO into a valid/ready pixel stream with sof/last markers.
// A 2-entry prefetch buffer hides the read latency so the stream sustains one word per cycle.
module fifo_stream_reader #(
    parameter int DW       = 8,
    parameter int LINE_LEN = 640,
    parameter int LINES    = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_rempty,
    output logic          fifo_ren,
    input  logic [DW-1:0] fifo_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_last,
    output logic          frame_done
);

    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(LINE_LEN - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(LINES - 1);

    logic [DW-1:0] buf_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic          inflight;
    logic [1:0]    cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          pop;
    logic [2:0]    level;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = buf_mem[rd_ptr];
    assign out_sof   = out_valid && (col == '0) && (row == '0);
    assign out_last  = out_valid && (col == COL_MAX);
    assign pop       = out_valid && out_ready;

    // level is the occupancy once this cycle's capture and pop settle; it is also next cnt.
    always_comb begin
        level    = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};
        fifo_ren = !rst && !fifo_rempty && (level < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            inflight   <= 1'b0;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            assert (level <= 3'd2);
            inflight   <= fifo_ren;
            cnt        <= level[1:0];
            frame_done <= pop && (col == COL_MAX) && (row == ROW_MAX);
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_rdata;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
